// File: rtl/pixel_row_feeder_pkg.sv
// Shared types and frame-geometry defaults for the pixel row feeder and
// the row-buffer window controller it feeds.
package pixel_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } feeder_state_e;

  localparam int unsigned PIX_W            = 8;
  localparam int unsigned DEF_IMG_WIDTH    = 512;
  localparam int unsigned DEF_IMG_HEIGHT   = 512;
  localparam int unsigned DEF_PREFILL_ROWS = 4;

  // Counter width that never collapses to zero bits for tiny parameters.
  function automatic int unsigned cnt_width(input int unsigned max_states);
    return (max_states <= 32'd2) ? 32'd1 : $clog2(max_states);
  endfunction

endpackage

// File: rtl/pixel_row_feeder_if.sv
// Source-side valid/ready bus and controller-side pixel bus of the feeder.
interface pixel_row_feeder_if;
  import pixel_feeder_pkg::*;

  logic [PIX_W-1:0] src_data;
  logic             src_valid;
  logic             src_ready;
  logic [PIX_W-1:0] pix_out;
  logic             pix_out_valid;

  modport master (
    input  src_data,
    input  src_valid,
    output src_ready,
    output pix_out,
    output pix_out_valid
  );

  modport slave (
    output src_data,
    output src_valid,
    input  src_ready,
    input  pix_out,
    input  pix_out_valid
  );

endinterface

// File: rtl/pixel_row_feeder_credit.sv
// Saturating row-credit counter: load to MAX_VAL, simultaneous inc/dec
// cancel, and an overflow pulse when an increment hits the ceiling.
module row_credit_counter #(
  parameter int unsigned MAX_VAL = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] ZERO_V = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             overflow_s;

  // Next credit value with saturation at both ends.
  always_comb begin
    count_next_s = count_r;
    overflow_s   = 1'b0;
    if (load) begin
      count_next_s = MAX_V;
    end else if (inc && !dec) begin
      if (count_r == MAX_V) begin
        overflow_s = 1'b1;
      end else begin
        count_next_s = count_r + ONE_V;
      end
    end else if (dec && !inc) begin
      if (count_r != ZERO_V) begin
        count_next_s = count_r - ONE_V;
      end else begin
        count_next_s = ZERO_V;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Credit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= ZERO_V;
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count      = count_r;
  assign count_next = count_next_s;
  assign overflow   = overflow_s;

endmodule

// File: rtl/pixel_row_feeder.sv
// Streams one frame of pixels from a valid/ready source to the window
// controller, pacing whole rows against controller row-read interrupts.
module pixel_row_feeder
  import pixel_feeder_pkg::*;
#(
  parameter int unsigned IMG_WIDTH    = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT   = DEF_IMG_HEIGHT,
  parameter int unsigned PREFILL_ROWS = DEF_PREFILL_ROWS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                irq_in,
  pixel_row_feeder_if.master  pix_if,
  output logic                busy,
  output logic                done,
  output logic                err_overflow
);

  localparam int unsigned COL_W  = cnt_width(IMG_WIDTH);
  localparam int unsigned ROW_W  = cnt_width(IMG_HEIGHT + 1);
  localparam int unsigned IRQ_W  = cnt_width(IMG_HEIGHT) + 1;
  localparam int unsigned CRED_W = cnt_width(PREFILL_ROWS + 1);

  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [IRQ_W-1:0]  IRQ_TARGET = IRQ_W'(IMG_HEIGHT - 2);
  localparam logic [IRQ_W-1:0]  IRQ_MAX    = {IRQ_W{1'b1}};
  localparam logic [CRED_W-1:0] CRED_ZERO  = {CRED_W{1'b0}};

  feeder_state_e     state_r;
  feeder_state_e     state_next_s;
  logic [COL_W-1:0]  col_cnt_r;
  logic [ROW_W-1:0]  row_cnt_r;
  logic [IRQ_W-1:0]  irq_cnt_r;
  logic [IRQ_W-1:0]  irq_cnt_next_s;
  logic [CRED_W-1:0] credits_s;
  logic [CRED_W-1:0] credits_next_s;
  logic              cred_overflow_s;
  logic              src_ready_r;
  logic [PIX_W-1:0]  pix_out_r;
  logic              pix_out_valid_r;
  logic              busy_r;
  logic              done_r;
  logic              err_overflow_r;
  logic              start_acc_s;
  logic              xfer_s;
  logic              row_done_s;
  logic              irq_live_s;

  assign start_acc_s = start && (state_r == IDLE);
  assign xfer_s      = pix_if.src_valid && src_ready_r;
  assign row_done_s  = xfer_s && (col_cnt_r == COL_LAST);
  // Interrupts only count inside a frame; IDLE ignores them completely.
  assign irq_live_s  = irq_in && busy_r;

  assign irq_cnt_next_s = (irq_live_s && (irq_cnt_r != IRQ_MAX)) ?
                          (irq_cnt_r + IRQ_W'(1)) : irq_cnt_r;

  row_credit_counter #(
    .MAX_VAL (PREFILL_ROWS),
    .CNT_W   (CRED_W)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .load       (start_acc_s),
    .inc        (irq_live_s),
    .dec        (row_done_s),
    .count      (credits_s),
    .count_next (credits_next_s),
    .overflow   (cred_overflow_s)
  );

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = SEND;
        else       state_next_s = IDLE;
      end
      SEND: begin
        if (row_done_s) begin
          if (row_cnt_r == ROW_LAST)            state_next_s = DRAIN;
          else if (credits_next_s == CRED_ZERO) state_next_s = WAIT;
          else                                  state_next_s = SEND;
        end else begin
          state_next_s = SEND;
        end
      end
      WAIT: begin
        if (credits_s != CRED_ZERO) state_next_s = SEND;
        else                        state_next_s = WAIT;
      end
      DRAIN: begin
        if (irq_cnt_next_s == IRQ_TARGET) state_next_s = IDLE;
        else                              state_next_s = DRAIN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State and state-decoded control outputs, registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      src_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      src_ready_r <= (state_next_s == SEND);
      busy_r      <= (state_next_s != IDLE);
      done_r      <= (state_r == DRAIN) && (state_next_s == IDLE);
    end
  end

  // Row/column/interrupt bookkeeping and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt_r      <= {COL_W{1'b0}};
      row_cnt_r      <= {ROW_W{1'b0}};
      irq_cnt_r      <= {IRQ_W{1'b0}};
      err_overflow_r <= 1'b0;
    end else if (start_acc_s) begin
      col_cnt_r      <= {COL_W{1'b0}};
      row_cnt_r      <= {ROW_W{1'b0}};
      irq_cnt_r      <= {IRQ_W{1'b0}};
      err_overflow_r <= 1'b0;
    end else begin
      if (row_done_s) begin
        col_cnt_r <= {COL_W{1'b0}};
        row_cnt_r <= row_cnt_r + ROW_W'(1);
      end else if (xfer_s) begin
        col_cnt_r <= col_cnt_r + COL_W'(1);
      end else begin
        col_cnt_r <= col_cnt_r;
      end
      irq_cnt_r      <= irq_cnt_next_s;
      err_overflow_r <= err_overflow_r || cred_overflow_s;
    end
  end

  // Output pixel register; data holds when nothing is transferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_out_r       <= {PIX_W{1'b0}};
      pix_out_valid_r <= 1'b0;
    end else begin
      pix_out_valid_r <= xfer_s;
      if (xfer_s) pix_out_r <= pix_if.src_data;
      else        pix_out_r <= pix_out_r;
    end
  end

  assign pix_if.src_ready     = src_ready_r;
  assign pix_if.pix_out       = pix_out_r;
  assign pix_if.pix_out_valid = pix_out_valid_r;
  assign busy                 = busy_r;
  assign done                 = done_r;
  assign err_overflow         = err_overflow_r;

endmodule

// File: tb/tb_pixel_row_feeder.sv
// Directed bench for pixel_row_feeder with W=8, H=6, P=4; source data is
// the running pixel index so every output pixel value is predictable.
module tb_pixel_row_feeder;
  import pixel_feeder_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned H = 6;
  localparam int unsigned P = 4;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic irq_in;
  logic busy;
  logic done;
  logic err_overflow;

  int n_assert = 0;
  int n_fail   = 0;
  int next_pix = 0;
  int out_cnt  = 0;
  int coll_cnt = 0;
  logic coll;

  pixel_row_feeder_if sif ();

  pixel_row_feeder #(
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .PREFILL_ROWS (P)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .irq_in       (irq_in),
    .pix_if       (sif.master),
    .busy         (busy),
    .done         (done),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: predict the transfer, then check the output pixel port.
  task automatic cyc();
    logic xfer;
    xfer = sif.src_valid && sif.src_ready && !rst;
    @(posedge clk);
    #1;
    chk1("pix_out_valid", sif.pix_out_valid, xfer);
    if (xfer) begin
      chk_int("pix_out", int'(sif.pix_out), next_pix % 256);
      next_pix++;
      out_cnt++;
    end
    sif.src_data = 8'(next_pix);
  endtask

  task automatic irq_pulse();
    irq_in = 1'b1;
    cyc();
    irq_in = 1'b0;
  endtask

  task automatic new_frame_counters();
    next_pix     = 0;
    out_cnt      = 0;
    sif.src_data = 8'd0;
  endtask

  initial begin
    // Reset with the source pushing and irq toggling.
    rst = 1'b1; start = 1'b0; irq_in = 1'b0;
    sif.src_valid = 1'b1; sif.src_data = 8'h5a;
    for (int i = 0; i < 3; i++) begin
      irq_in = (i % 2 == 0);
      cyc();
    end
    chk1("rst_src_ready", sif.src_ready, 1'b0);
    chk1("rst_pix_valid", sif.pix_out_valid, 1'b0);
    chk_int("rst_pix_out", int'(sif.pix_out), 0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err_overflow, 1'b0);
    rst = 1'b0; irq_in = 1'b0; sif.src_valid = 1'b0;
    cyc();

    // Frame 1: prefill four rows back to back.
    new_frame_counters();
    sif.src_valid = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk1("start_busy", busy, 1'b1);
    chk1("start_ready", sif.src_ready, 1'b1);
    repeat (34) cyc();
    chk_int("prefill_count", out_cnt, 32);
    chk1("prefill_wait_ready", sif.src_ready, 1'b0);
    chk1("prefill_busy", busy, 1'b1);

    // One interrupt releases exactly one row.
    irq_pulse();
    cyc();
    cyc();
    chk1("credit_ready_by_t2", sif.src_ready, 1'b1);
    repeat (12) cyc();
    chk_int("row5_count", out_cnt, 40);
    chk1("row5_wait_ready", sif.src_ready, 1'b0);

    irq_pulse();
    repeat (14) cyc();
    chk_int("row6_count", out_cnt, 48);
    chk1("drain_ready", sif.src_ready, 1'b0);
    chk1("drain_busy", busy, 1'b1);
    chk1("drain_done", done, 1'b0);

    // Completion on the fourth interrupt.
    irq_pulse();
    chk1("irq3_done", done, 1'b0);
    cyc();
    irq_pulse();
    chk1("irq4_done", done, 1'b1);
    chk1("irq4_busy", busy, 1'b0);
    cyc();
    chk1("done_one_cycle", done, 1'b0);
    irq_pulse();
    irq_pulse();
    cyc();
    chk1("idle_irq_busy", busy, 1'b0);
    chk1("idle_irq_done", done, 1'b0);
    chk1("idle_irq_err", err_overflow, 1'b0);
    chk_int("idle_irq_count", out_cnt, 48);

    // Frame 2: gappy source, irq coinciding with the row-4 last pixel.
    new_frame_counters();
    sif.src_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 90; i++) begin
      sif.src_valid = (i % 2 == 0);
      coll = sif.src_valid && sif.src_ready && (next_pix == 31);
      irq_in = coll;
      cyc();
      irq_in = 1'b0;
      if (coll) begin
        coll_cnt++;
        chk1("collision_no_bubble", sif.src_ready, 1'b1);
      end
    end
    chk_int("collision_seen", coll_cnt, 1);
    chk_int("gap_count_40", out_cnt, 40);
    chk1("gap_wait_ready", sif.src_ready, 1'b0);
    irq_pulse();
    for (int i = 0; i < 30; i++) begin
      sif.src_valid = (i % 2 == 0);
      cyc();
    end
    chk_int("gap_count_48", out_cnt, 48);
    chk1("gap_drain_ready", sif.src_ready, 1'b0);
    irq_pulse();
    chk1("gap_done_early", done, 1'b0);
    irq_pulse();
    chk1("gap_done", done, 1'b1);
    chk1("gap_busy", busy, 1'b0);

    // Frame 3: interrupts with full credits, then reset mid-row.
    new_frame_counters();
    sif.src_valid = 1'b0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk1("ovf_err_clear", err_overflow, 1'b0);
    for (int i = 0; i < 5; i++) begin
      irq_pulse();
      cyc();
    end
    chk1("ovf_err_set", err_overflow, 1'b1);
    repeat (3) cyc();
    chk1("ovf_err_sticky", err_overflow, 1'b1);
    sif.src_valid = 1'b1;
    repeat (3) cyc();
    chk_int("partial_row", out_cnt, 3);
    rst = 1'b1;
    cyc();
    chk1("midrst_ready", sif.src_ready, 1'b0);
    chk1("midrst_pix_valid", sif.pix_out_valid, 1'b0);
    chk_int("midrst_pix_out", int'(sif.pix_out), 0);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_done", done, 1'b0);
    chk1("midrst_err", err_overflow, 1'b0);
    rst = 1'b0;
    new_frame_counters();
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (10) cyc();
    chk_int("restart_count", out_cnt, 10);
    chk1("restart_busy", busy, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_row_feeder.md
# pixel_row_feeder

Source-side streaming engine feeding the row-buffer window controller. Pulls 8-bit pixels of one frame from an upstream source over a valid/ready handshake and emits them on the controller's pixel input port (data + valid, no backpressure). Paces transmission with a row-credit scheme driven by the controller's end-of-window-row interrupt, so no row buffer is overwritten before it has been read. Sits between the frame source (DMA / test memory) and the window controller.

## Interface
- IMG_WIDTH, 512, pixels per row; must equal the controller row-buffer depth
- IMG_HEIGHT, 512, rows per frame; minimum 3
- PREFILL_ROWS, 4, row buffers in the controller; initial and maximum credit count
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- start  input  1  one-cycle pulse; begins a frame; ignored while busy=1
- src_data  input  8  pixel from source
- src_valid  input  1  src_data valid
- src_ready  output  1  feeder accepts src_data this cycle
- pix_out  output  8  pixel to controller input_pixel_values
- pix_out_valid  output  1  to controller input_pixel_values_valid
- irq_in  input  1  controller output_interrupt; one-cycle pulse per window row read
- busy  output  1  high from start acceptance until done
- done  output  1  one-cycle pulse at frame completion
- err_overflow  output  1  sticky; interrupt arrived with credits already at PREFILL_ROWS; cleared by start or rst

## Operation
- States: IDLE, SEND, WAIT, DRAIN.
- IDLE: start → clear col_cnt, row_cnt, irq_cnt, err_overflow; credits = PREFILL_ROWS; busy=1; go SEND.
- src_ready = 1 only in SEND. Transfer = src_valid & src_ready.
- Each transfer: col_cnt++. On transfer with col_cnt == IMG_WIDTH-1: col_cnt=0, row_cnt++, credits--.
- SEND, row-completing transfer: if row_cnt+1 == IMG_HEIGHT → DRAIN; else if updated credits == 0 → WAIT; else stay SEND (no bubble).
- WAIT: credits > 0 → SEND.
- Credits: irq_in while busy → credits++. irq_in and row completion in same cycle → net unchanged. irq_in at credits == PREFILL_ROWS (and no completion same cycle) → saturate, set err_overflow.
- irq_cnt increments on every irq_in while busy (width clog2(IMG_HEIGHT)+1).
- DRAIN: when irq_cnt == IMG_HEIGHT-2 (count including an irq_in in the current cycle) → done pulse, busy=0, IDLE. Also checked on the cycle of entry into DRAIN.
- irq_in in IDLE ignored entirely. start while busy ignored.
- Counter widths: col_cnt clog2(IMG_WIDTH), row_cnt clog2(IMG_HEIGHT+1), credits clog2(PREFILL_ROWS+1); no wrap beyond defined limits.

## Timing
- Reset values: src_ready 0, pix_out 0, pix_out_valid 0, busy 0, done 0, err_overflow 0; state IDLE.
- Start accepted cycle t → busy=1, src_ready=1 at t+1.
- Pixel transferred at cycle t → pix_out = that pixel, pix_out_valid=1 at t+1; otherwise pix_out_valid=0 (pix_out holds).
- Last pixel of a row with zero remaining credits: src_ready=0 from the next cycle.
- irq_in at cycle t in WAIT → src_ready=1 at t+2 (credit registered t+1, state SEND t+1, ready is state-decoded: 1 at t+1 is also legal only if credits>0 registered; required: ready at t+2 at latest, never before credit visible).
- done registered: asserted cycle after final qualifying irq_in, one cycle wide; busy falls same cycle.
- rst mid-frame: next cycle all outputs at reset values, partial row discarded.

## Structure
- Package pixel_feeder_pkg: state enum (IDLE, SEND, WAIT, DRAIN), default IMG_WIDTH/IMG_HEIGHT/PREFILL_ROWS constants shared with the window controller.
- One sub-module: row_credit_counter (saturating up/down counter with simultaneous inc/dec and overflow flag).
- Output pixel register and control FSM in top level.

## Test plan
- Reset: hold rst 3 cycles with src_valid=1, irq_in toggling → all outputs 0, no src_ready.
- Prefill (W=8, H=6, P=4): start, src_valid=1, src_data=index → pix_out 0..31 on 32 consecutive cycles, first one cycle after first transfer; then src_ready=0, state WAIT.
- Credit pacing: irq_in in WAIT → row 32..39 streamed, WAIT; second irq_in → row 40..47, DRAIN, src_ready stays 0.
- Completion: 4 irq_in total (H-2) → done pulse one cycle after 4th, busy=0; further irq_in no effect, err_overflow=0.
- Source gaps / collisions: src_valid toggling 1010… → pix_out_valid mirrors one cycle delayed, 48 pixels total; irq_in on last pixel of row with credits=1 → next row continues with no bubble.
- Overflow and reset: 5 irq_in while credits=4 (before any row completes in a P=4, custom stimulus) → err_overflow=1 sticky; rst mid-row → all outputs 0 next cycle, new start streams from pixel 0.
